// File: rtl/aip_seq_pkg.sv
// Shared state encoding and command/status/interrupt bit positions for the AIP core sequencer.
package aip_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DONE,
        S_ABORT
    } seq_state_e;

    localparam int unsigned CMD_START     = 0;
    localparam int unsigned CMD_ABORT     = 1;
    localparam int unsigned CMD_LIMIT_LSB = 16;

    localparam int unsigned ST_BUSY       = 0;
    localparam int unsigned ST_OVERRUN    = 1;

    localparam int unsigned INT_DONE      = 0;
    localparam int unsigned INT_TIMEOUT   = 1;
    localparam int unsigned INT_ABORT     = 2;

endpackage

// File: rtl/aip_seq_watchdog.sv
// Busy-cycle watchdog: saturating counter plus a per-run limit latched at start acceptance.
module aip_seq_watchdog #(
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_count,
    input  logic [TIMEOUT_W-1:0] i_limit,
    output logic                 o_expire_c
);

    logic [TIMEOUT_W-1:0] r_count;
    logic [TIMEOUT_W-1:0] r_limit;

    // Count resets to zero on load, so the first busy cycle observes a count of 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_limit <= '0;
        end else if (i_load) begin
            r_count <= '0;
            r_limit <= i_limit;
        end else if (i_count && (r_count != '1)) begin
            r_count <= r_count + TIMEOUT_W'(1);
        end
    end

    // A zero limit disables the timeout for that run.
    assign o_expire_c = (r_limit != '0) && (r_count == r_limit);

endmodule

// File: rtl/aip_core_sequencer.sv
// Start/abort sequencer between the AIP command register and the IP core.
// Optional watchdog timeout enabled by defining AIP_SEQ_WATCHDOG_EN.
module aip_core_sequencer
    import aip_seq_pkg::*;
#(
    parameter int unsigned REGWIDTH    = 32,
    parameter int unsigned STATUSFLAGS = 8,
    parameter int unsigned INTFLAGS    = 8,
    parameter int unsigned TIMEOUT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enCmd,
    input  logic [REGWIDTH-1:0]    dataIn,
    input  logic                   coreDone,
    output logic                   coreStart,
    output logic                   coreClear,
    output logic [STATUSFLAGS-1:0] statusIP,
    output logic [INTFLAGS-1:0]    intIP
);

    seq_state_e             r_state;
    logic                   r_core_start;
    logic                   r_core_clear;
    logic [STATUSFLAGS-1:0] r_status;
    logic [INTFLAGS-1:0]    r_int;

    logic                   w_start_cmd;
    logic                   w_abort_cmd;
    logic                   w_accept;
    logic                   w_expire;
    logic [TIMEOUT_W-1:0]   w_limit;
    logic                   w_unused;

    assign w_start_cmd = enCmd & dataIn[CMD_START];
    assign w_abort_cmd = enCmd & dataIn[CMD_ABORT];
    assign w_accept    = (r_state == S_IDLE) & w_start_cmd & ~dataIn[CMD_ABORT];
    assign w_limit     = dataIn[CMD_LIMIT_LSB +: TIMEOUT_W];
    assign w_unused    = ^{dataIn, w_limit};

`ifdef AIP_SEQ_WATCHDOG_EN
    aip_seq_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_count    (r_state == S_BUSY),
        .i_limit    (w_limit),
        .o_expire_c (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // Outputs are registered alongside the state they belong to, so pulses appear in the entered state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_core_start <= 1'b0;
            r_core_clear <= 1'b0;
            r_status     <= '0;
            r_int        <= '0;
        end else begin
            r_core_start <= 1'b0;
            r_core_clear <= 1'b0;
            r_int        <= '0;
            if (w_start_cmd && (r_state != S_IDLE)) begin
                r_status[ST_OVERRUN] <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state              <= S_START;
                        r_core_start         <= 1'b1;
                        r_status[ST_BUSY]    <= 1'b1;
                        r_status[ST_OVERRUN] <= 1'b0;
                    end
                end
                S_START: begin
                    if (coreDone) begin
                        r_state           <= S_DONE;
                        r_int[INT_DONE]   <= 1'b1;
                        r_status[ST_BUSY] <= 1'b0;
                    end else begin
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Completion wins over a simultaneous abort, abort wins over timeout.
                    if (coreDone) begin
                        r_state           <= S_DONE;
                        r_int[INT_DONE]   <= 1'b1;
                        r_status[ST_BUSY] <= 1'b0;
                    end else if (w_abort_cmd) begin
                        r_state           <= S_ABORT;
                        r_core_clear      <= 1'b1;
                        r_int[INT_ABORT]  <= 1'b1;
                        r_status[ST_BUSY] <= 1'b0;
                    end else if (w_expire) begin
                        r_state            <= S_ABORT;
                        r_core_clear       <= 1'b1;
                        r_int[INT_TIMEOUT] <= 1'b1;
                        r_status[ST_BUSY]  <= 1'b0;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ABORT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign coreStart = r_core_start;
    assign coreClear = r_core_clear;
    assign statusIP  = r_status;
    assign intIP     = r_int;

endmodule

// File: tb/tb_aip_core_sequencer.sv
// Self-checking bench for aip_core_sequencer: directed scenarios then random traffic vs. a cycle-stamp model.
// Watchdog expectations follow AIP_SEQ_WATCHDOG_EN.
module tb_aip_core_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enCmd;
    logic [31:0] dataIn;
    logic        coreDone;
    logic        coreStart;
    logic        coreClear;
    logic [7:0]  statusIP;
    logic [7:0]  intIP;

    int checks = 0;
    int errors = 0;

    // Model: a run is described by the cycle its start was accepted and the cycle the sequencer is free again.
    logic        e_start, e_clear;
    logic [7:0]  e_status, e_int;
    bit          act;
    bit          ovr;
    int          acc_cyc;
    int          free_at;
    int          t;
    int unsigned lim;

    aip_core_sequencer #(
        .REGWIDTH    (32),
        .STATUSFLAGS (8),
        .INTFLAGS    (8),
        .TIMEOUT_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enCmd     (enCmd),
        .dataIn    (dataIn),
        .coreDone  (coreDone),
        .coreStart (coreStart),
        .coreClear (coreClear),
        .statusIP  (statusIP),
        .intIP     (intIP)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".coreStart"}, {7'd0, coreStart}, {7'd0, e_start});
        check({tag, ".coreClear"}, {7'd0, coreClear}, {7'd0, e_clear});
        check({tag, ".statusIP"}, statusIP, e_status);
        check({tag, ".intIP"}, intIP, e_int);
        check({tag, ".int_onehot"}, 8'($countones(intIP) <= 1), 8'd1);
    endtask

    task automatic model_reset();
        act = 0; ovr = 0; free_at = 0;
        e_start = 0; e_clear = 0; e_status = '0; e_int = '0;
    endtask

    function automatic bit timed_out(input int busy_cycles);
`ifdef AIP_SEQ_WATCHDOG_EN
        int cnt;
        cnt = (busy_cycles > 65535) ? 65535 : busy_cycles;
        return (lim != 0) && (cnt == int'(lim));
`else
        return (busy_cycles < 0);
`endif
    endfunction

    // Predict the outputs of cycle t+1 from the inputs seen in cycle t.
    task automatic model_step(input logic en, input logic [31:0] d, input logic dn);
        bit busy_n;
        int age;
        busy_n = 0; e_start = 0; e_clear = 0; e_int = '0;
        if (!act && t >= free_at) begin
            if (en && d[0] && !d[1]) begin
                act = 1; acc_cyc = t; lim = int'(d[31:16]); ovr = 0;
                e_start = 1; busy_n = 1;
            end
        end else begin
            if (en && d[0]) ovr = 1;
            if (act) begin
                age = t - acc_cyc;
                if (dn) begin
                    e_int = 8'h01; act = 0; free_at = t + 2;
                end else if (age >= 2 && en && d[1]) begin
                    e_int = 8'h04; e_clear = 1; act = 0; free_at = t + 2;
                end else if (age >= 2 && timed_out(age - 2)) begin
                    e_int = 8'h02; e_clear = 1; act = 0; free_at = t + 2;
                end else begin
                    busy_n = 1;
                end
            end
        end
        e_status = {6'd0, ovr, busy_n};
        t++;
    endtask

    task automatic step(input string tag, input logic en, input logic [31:0] d, input logic dn);
        enCmd = en; dataIn = d; coreDone = dn;
        @(negedge clk);
        check_all(tag);
        model_step(en, d, dn);
        @(posedge clk); #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic async_reset(input string tag);
        enCmd = 0; dataIn = '0; coreDone = 0;
        @(negedge clk); #2;
        rst = 1'b0; #1;
        model_reset();
        check_all(tag);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; enCmd = 0; dataIn = '0; coreDone = 0; t = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset");
        rst = 1'b1;

        // Quiet after reset
        idle("quiet", 20);

        // Start then completion four busy cycles later
        step("t2_start", 1'b1, 32'h0000_0001, 1'b0);
        idle("t2_busy", 4);
        step("t2_done", 1'b0, 32'h0, 1'b1);
        idle("t2_tail", 3);

        // Host abort, then a stray completion
        step("t3_start", 1'b1, 32'h0000_0001, 1'b0);
        idle("t3_busy", 2);
        step("t3_abort", 1'b1, 32'h0000_0002, 1'b0);
        idle("t3_tail", 2);
        step("t3_stray", 1'b0, 32'h0, 1'b1);
        idle("t3_tail2", 2);

        // Watchdog limit 4, then limit 0 ended by host abort
        step("t4_start", 1'b1, 32'h0004_0001, 1'b0);
        idle("t4_wait", 12);
        step("t4_start0", 1'b1, 32'h0000_0001, 1'b0);
        idle("t4_wait0", 20);
        step("t4_abort0", 1'b1, 32'h0000_0002, 1'b0);
        idle("t4_tail", 2);

        // Overrun on start while busy, cleared by the next accepted start
        step("t5_start", 1'b1, 32'h0000_0001, 1'b0);
        idle("t5_busy", 1);
        step("t5_again", 1'b1, 32'h0000_0001, 1'b0);
        idle("t5_busy2", 2);
        step("t5_done", 1'b0, 32'h0, 1'b1);
        step("t5_b2b", 1'b1, 32'h0000_0001, 1'b0);
        step("t5_next", 1'b1, 32'h0000_0001, 1'b0);
        idle("t5_busy3", 2);
        step("t5_done2", 1'b0, 32'h0, 1'b1);
        idle("t5_tail", 2);

        // Completion and abort in the same busy cycle; start+abort together in idle
        step("t6_start", 1'b1, 32'h0000_0001, 1'b0);
        idle("t6_busy", 2);
        step("t6_both", 1'b1, 32'h0000_0002, 1'b1);
        idle("t6_tail", 2);
        step("t6_sa", 1'b1, 32'h0000_0003, 1'b0);
        idle("t6_tail2", 2);

        // Reset while busy
        step("rst_start", 1'b1, 32'h0000_0001, 1'b0);
        idle("rst_busy", 2);
        async_reset("rst_mid");
        idle("rst_after", 5);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic        r_en;
            logic [31:0] r_d;
            logic        r_dn;
            if ($urandom_range(0, 299) == 0) begin
                async_reset("rnd_rst");
            end else begin
                r_en = ($urandom_range(0, 3) == 0);
                r_d  = {16'($urandom_range(0, 8)), 14'd0, 2'($urandom)};
                r_dn = ($urandom_range(0, 11) == 0);
                step("rnd", r_en, r_d, r_dn);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
